// File: rtl/pipe_ctrl.sv
// pipe_ctrl: front-end sequencer that turns execute jump/hold requests and
// the decode load-use hazard into PC redirect, stall and flush controls,
// with a post-jump flush window, a hold watchdog and performance counters.
module pipe_ctrl #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned HOLD_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_flag_i,
  input  logic              load_use_i,
  output logic              pc_jump_en_o,
  output logic [ADDR_W-1:0] pc_jump_addr_o,
  output logic              hold_pc_o,
  output logic              hold_if_id_o,
  output logic              hold_id_ex_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic              hold_timeout_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       redirect_cnt_o
);

  localparam int unsigned FCNT_W = 3;
  localparam int unsigned HCNT_W = 8;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic                timeout_q;
  logic [31:0]         stall_q;
  logic [31:0]         redir_q;

  logic                run_decode_c;
  logic                wd_fire_c;
  logic                pc_jump_en_c;
  logic [ADDR_W-1:0]   pc_jump_addr_c;
  logic                hold_pc_c;
  logic                hold_if_id_c;
  logic                hold_id_ex_c;
  logic                flush_if_id_c;
  logic                flush_id_ex_c;

  // State, window counters and sticky watchdog flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RUN;
      fcnt_q    <= '0;
      hcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      hcnt_q    <= hcnt_d;
      timeout_q <= timeout_q | wd_fire_c;
    end
  end

  // Performance counters, free-running with natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      stall_q <= stall_q + 32'(hold_pc_c);
      redir_q <= redir_q + 32'(pc_jump_en_c);
    end
  end

  // Next-state and control decode; HOLD falls back to RUN decoding on jump or release
  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    hcnt_d         = hcnt_q;
    wd_fire_c      = 1'b0;
    pc_jump_en_c   = 1'b0;
    pc_jump_addr_c = '0;
    hold_pc_c      = 1'b0;
    hold_if_id_c   = 1'b0;
    hold_id_ex_c   = 1'b0;
    flush_if_id_c  = 1'b0;
    flush_id_ex_c  = 1'b0;
    run_decode_c   = 1'b0;

    case (state_q)
      S_FLUSH: begin
        flush_if_id_c = 1'b1;
        flush_id_ex_c = 1'b1;
        fcnt_d        = fcnt_q - FCNT_W'(1);
        if (fcnt_q <= FCNT_W'(1)) begin
          state_d = S_RUN;
          fcnt_d  = '0;
        end
      end
      S_HOLD: begin
        if (!jump_en_i && hold_flag_i) begin
          if (({1'b0, hcnt_q} + 9'd1) == 9'(HOLD_TIMEOUT)) begin
            wd_fire_c = 1'b1;
            state_d   = S_RUN;
            hcnt_d    = '0;
          end else begin
            hold_pc_c    = 1'b1;
            hold_if_id_c = 1'b1;
            hold_id_ex_c = 1'b1;
            hcnt_d       = hcnt_q + HCNT_W'(1);
          end
        end else begin
          run_decode_c = 1'b1;
        end
      end
      default: run_decode_c = 1'b1;
    endcase

    if (run_decode_c) begin
      state_d = S_RUN;
      hcnt_d  = '0;
      if (jump_en_i) begin
        pc_jump_en_c   = 1'b1;
        pc_jump_addr_c = jump_addr_i;
        flush_if_id_c  = 1'b1;
        flush_id_ex_c  = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = S_FLUSH;
          fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
        end
      end else if (hold_flag_i) begin
        hold_pc_c    = 1'b1;
        hold_if_id_c = 1'b1;
        hold_id_ex_c = 1'b1;
        state_d      = S_HOLD;
        hcnt_d       = HCNT_W'(1);
      end else if (load_use_i) begin
        hold_pc_c     = 1'b1;
        hold_if_id_c  = 1'b1;
        flush_id_ex_c = 1'b1;
      end
    end
  end

  // Outputs are forced low while reset is held
  assign pc_jump_en_o   = !rst && pc_jump_en_c;
  assign pc_jump_addr_o = rst ? '0 : pc_jump_addr_c;
  assign hold_pc_o      = !rst && hold_pc_c;
  assign hold_if_id_o   = !rst && hold_if_id_c;
  assign hold_id_ex_o   = !rst && hold_id_ex_c;
  assign flush_if_id_o  = !rst && flush_if_id_c;
  assign flush_id_ex_o  = !rst && flush_id_ex_c;
  assign hold_timeout_o = !rst && (timeout_q || wd_fire_c);
  assign stall_cnt_o    = rst ? '0 : stall_q;
  assign redirect_cnt_o = rst ? '0 : redir_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl with a cycle-level reference model.
module tb_pipe_ctrl;
  localparam int unsigned AW = 32;
  localparam int unsigned FC = 3;
  localparam int unsigned HT = 6;

  typedef struct packed {
    logic        pje;
    logic [31:0] addr;
    logic        hpc;
    logic        hif;
    logic        hie;
    logic        fif;
    logic        fie;
    logic        to;
    logic [31:0] sc;
    logic [31:0] rc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          jump_en;
  logic [AW-1:0] jump_addr;
  logic          hold_flag;
  logic          load_use;
  logic          pc_jump_en;
  logic [AW-1:0] pc_jump_addr;
  logic          hold_pc, hold_if_id, hold_id_ex;
  logic          flush_if_id, flush_id_ex;
  logic          hold_timeout;
  logic [31:0]   stall_cnt, redirect_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .HOLD_TIMEOUT(HT)) dut (
    .clk            (clk),
    .rst            (rst),
    .jump_en_i      (jump_en),
    .jump_addr_i    (jump_addr),
    .hold_flag_i    (hold_flag),
    .load_use_i     (load_use),
    .pc_jump_en_o   (pc_jump_en),
    .pc_jump_addr_o (pc_jump_addr),
    .hold_pc_o      (hold_pc),
    .hold_if_id_o   (hold_if_id),
    .hold_id_ex_o   (hold_id_ex),
    .flush_if_id_o  (flush_if_id),
    .flush_id_ex_o  (flush_id_ex),
    .hold_timeout_o (hold_timeout),
    .stall_cnt_o    (stall_cnt),
    .redirect_cnt_o (redirect_cnt)
  );

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;

  // Reference model: remaining flush cycles, length of the current stall run
  int          m_flush = 0;
  int          m_hold  = 0;
  logic        m_to    = 1'b0;
  logic [31:0] m_sc    = '0;
  logic [31:0] m_rc    = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the response the model predicts
  task automatic apply(input logic r, input logic j, input logic [31:0] a,
                       input logic h, input logic lu);
    exp_t e;
    rst = r; jump_en = j; jump_addr = a; hold_flag = h; load_use = lu;
    e = '0;
    if (r) begin
      m_flush = 0; m_hold = 0; m_to = 1'b0; m_sc = '0; m_rc = '0;
    end else begin
      e.sc = m_sc;
      e.rc = m_rc;
      if (m_flush > 0) begin
        e.fif = 1'b1; e.fie = 1'b1;
        m_flush--;
      end else if (j) begin
        e.pje = 1'b1; e.addr = a; e.fif = 1'b1; e.fie = 1'b1;
        m_flush = FC - 1;
        m_hold  = 0;
      end else if (h) begin
        if (m_hold + 1 == HT) begin
          m_to   = 1'b1;
          m_hold = 0;
        end else begin
          e.hpc = 1'b1; e.hif = 1'b1; e.hie = 1'b1;
          m_hold++;
        end
      end else begin
        m_hold = 0;
        if (lu) begin
          e.hpc = 1'b1; e.hif = 1'b1; e.fie = 1'b1;
        end
      end
      e.to = m_to;
      m_sc = m_sc + 32'(e.hpc);
      m_rc = m_rc + 32'(e.pje);
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic j, input logic [31:0] a,
                      input logic h, input logic lu);
    @(posedge clk);
    #1;
    apply(r, j, a, h, lu);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a full control word; compare at negedge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_jump_en",   32'(pc_jump_en),   32'(e.pje));
        chk("pc_jump_addr", pc_jump_addr,      e.addr);
        chk("hold_pc",      32'(hold_pc),      32'(e.hpc));
        chk("hold_if_id",   32'(hold_if_id),   32'(e.hif));
        chk("hold_id_ex",   32'(hold_id_ex),   32'(e.hie));
        chk("flush_if_id",  32'(flush_if_id),  32'(e.fif));
        chk("flush_id_ex",  32'(flush_id_ex),  32'(e.fie));
        chk("hold_timeout", 32'(hold_timeout), 32'(e.to));
        chk("stall_cnt",    stall_cnt,         e.sc);
        chk("redirect_cnt", redirect_cnt,      e.rc);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic
  initial begin
    int burst;
    logic r, j, h, lu;
    rst = 1'b1; jump_en = 1'b0; jump_addr = '0; hold_flag = 1'b0; load_use = 1'b0;

    // reset with conflicting requests present
    step(1'b1, 1'b1, 32'h0000_0444, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0444, 1'b1, 1'b0);
    idle(2);

    // jump with flush window
    step(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    idle(3);

    // jump and hold together: jump wins, no stall
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
    idle(3);

    // requests during the flush window are ignored
    step(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0304, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    idle(1);

    // five-cycle hold released with a load-use hazard
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(1);

    // jump breaks an active hold
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'hDEAD_BEE0, 1'b1, 1'b0);
    idle(3);

    // watchdog: hold stuck beyond the timeout, flag stays sticky
    for (int i = 0; i < 2 * HT + 2; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
    idle(3);

    // reset in the middle of a hold and of a flush window
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(2);

    // stall counter wrap
    @(posedge clk);
    #1;
    force dut.stall_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_q;
    m_sc = 32'hFFFF_FFFF;
    apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(2);

    // randomized traffic with occasional long hold bursts
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 249) == 0);
      j  = ($urandom_range(0, 9) == 0);
      lu = ($urandom_range(0, 4) == 0);
      if (burst > 0) begin
        h = 1'b1;
        burst--;
      end else begin
        h = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 39) == 0) burst = $urandom_range(HT - 2, HT + 3);
      end
      if (burst > 0) j = 1'b0;
      step(r, j, $urandom, h, lu);
    end
    idle(2);

    // drain: the monitor must have consumed every queued expectation
    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
